sram_arbiter: RTL and testbench

Sequencer and two-port arbiter for the board's 8-bit asynchronous SRAM (19-bit address) in the menu core. It shares the single SRAM bus between two requesters:
- the video fetch port, which reads one 32-bit pixel as four consecutive bytes;
- the ioctl download port, which writes single bytes.

It replaces the ad-hoc case machine and the edge-clocked request flops in the top level with toggle handshakes in one clock domain. Its outputs drive `SRAM_ADDR`, `SRAM_WE_N` and the `SRAM_DQ` tristate directly.

---
 rtl/sram_arb_pkg.sv | 37 +++
 rtl/sram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM sequencer/arbiter.
// Holds the FSM state encoding, the byte lanes of the assembled 32-bit video
// word (byte offset 0 is the most significant byte) and the last-served flag values.
package sram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_RD3,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } arb_state_e;

    // Bit position of each byte offset inside vid_q (big-endian word).
    localparam logic [4:0] LANE0_LSB = 5'd24;
    localparam logic [4:0] LANE1_LSB = 5'd16;
    localparam logic [4:0] LANE2_LSB = 5'd8;
    localparam logic [4:0] LANE3_LSB = 5'd0;

    // Encoding of the "port served last" flag used for tie-breaking.
    localparam logic SERVED_VID = 1'b0;
    localparam logic SERVED_WR  = 1'b1;

    // Return word with one byte lane replaced.
    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [4:0]  lsb,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[lsb +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Purpose: sequences the 8-bit async SRAM and arbitrates it between the video
//          word-fetch port (4 byte reads) and the ioctl byte-write port.
// Latency: read ack 4 edges after the request is seen (5-cycle period);
//          write ack WR_PULSE+2 edges after the request is seen.
// Backpressure: toggle handshakes; a request stays pending until its ack
//          toggles, ties alternate between ports.
// Ports: clk_ram/reset_n; vid_req/vid_addr -> vid_ack/vid_q;
//        wr_req/wr_addr/wr_data -> wr_ack; SRAM pins sram_addr, sram_dq_o,
//        sram_dq_oe, sram_dq_i, sram_we_n; busy = not IDLE.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int WR_PULSE = 1
) (
    input  logic              clk_ram,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [31:0]       vid_q,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dq_o,
    output logic              sram_dq_oe,
    input  logic [7:0]        sram_dq_i,
    output logic              sram_we_n,
    output logic              busy
);

    // Counter is loaded with WR_PULSE-1 and strobe rises after it reaches 0.
    localparam logic [3:0]        PULSE_LOAD = 4'(WR_PULSE - 1);
    // Clears the byte offset of the video word address.
    localparam logic [ADDR_W-1:0] WORD_MASK  = ~ADDR_W'(3);

    arb_state_e        state_q;
    logic              last_q;
    logic              vid_ack_q;
    logic              wr_ack_q;
    logic [31:0]       vid_q_q;
    logic [31:0]       asm_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        dq_o_q;
    logic              oe_q;
    logic              we_n_q;
    logic [3:0]        cnt_q;

    logic vid_pend;
    logic wr_pend;
    logic pick_vid;

    assign vid_pend = vid_req ^ vid_ack_q;
    assign wr_pend  = wr_req ^ wr_ack_q;
    // Video wins when alone, or on a tie when the write port was served last.
    assign pick_vid = vid_pend && (!wr_pend || (last_q == SERVED_WR));

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            last_q    <= SERVED_WR;
            vid_ack_q <= 1'b0;
            wr_ack_q  <= 1'b0;
            vid_q_q   <= '0;
            asm_q     <= '0;
            addr_q    <= '0;
            dq_o_q    <= '0;
            oe_q      <= 1'b0;
            we_n_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vid) begin
                        addr_q  <= vid_addr & WORD_MASK;
                        last_q  <= SERVED_VID;
                        state_q <= ST_RD0;
                    end else if (wr_pend) begin
                        addr_q  <= wr_addr;
                        dq_o_q  <= wr_data;
                        oe_q    <= 1'b1;
                        last_q  <= SERVED_WR;
                        state_q <= ST_WR_SETUP;
                    end
                end
                // Each read state samples the byte addressed one cycle earlier.
                ST_RD0: begin
                    asm_q       <= put_lane(asm_q, LANE0_LSB, sram_dq_i);
                    addr_q[1:0] <= 2'd1;
                    state_q     <= ST_RD1;
                end
                ST_RD1: begin
                    asm_q       <= put_lane(asm_q, LANE1_LSB, sram_dq_i);
                    addr_q[1:0] <= 2'd2;
                    state_q     <= ST_RD2;
                end
                ST_RD2: begin
                    asm_q       <= put_lane(asm_q, LANE2_LSB, sram_dq_i);
                    addr_q[1:0] <= 2'd3;
                    state_q     <= ST_RD3;
                end
                ST_RD3: begin
                    // Whole word published at once; never a partial word.
                    vid_q_q   <= put_lane(asm_q, LANE3_LSB, sram_dq_i);
                    vid_ack_q <= ~vid_ack_q;
                    state_q   <= ST_IDLE;
                end
                ST_WR_SETUP: begin
                    we_n_q  <= 1'b0;
                    cnt_q   <= PULSE_LOAD;
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        we_n_q  <= 1'b1;
                        state_q <= ST_WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    oe_q     <= 1'b0;
                    wr_ack_q <= ~wr_ack_q;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vid_ack    = vid_ack_q;
    assign vid_q      = vid_q_q;
    assign wr_ack     = wr_ack_q;
    assign sram_addr  = addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = oe_q;
    assign sram_we_n  = we_n_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: board SRAM model on the pins, a reference memory
// updated on acknowledged writes, and a transaction-level model of service
// order and latency. Inputs driven and outputs sampled on the falling edge.
module tb_sram_arbiter;

    localparam int AW  = 19;
    localparam int WRP = 3;

    logic          clk_ram;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [31:0]   vid_q;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ack;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_dq_o;
    logic          sram_dq_oe;
    logic [7:0]    sram_dq_i;
    logic          sram_we_n;
    logic          busy;

    sram_arbiter #(.ADDR_W(AW), .WR_PULSE(WRP)) dut (
        .clk_ram    (clk_ram),
        .reset_n    (reset_n),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_ack    (vid_ack),
        .vid_q      (vid_q),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_i  (sram_dq_i),
        .sram_we_n  (sram_we_n),
        .busy       (busy)
    );

    initial clk_ram = 1'b0;
    always #5 clk_ram = ~clk_ram;

    // Board SRAM: asynchronous read, write while strobe is low.
    logic [7:0] mem     [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    assign sram_dq_i = mem[sram_addr];
    always @(posedge clk_ram) begin
        if (sram_we_n === 1'b0) mem[sram_addr] = sram_dq_oe ? sram_dq_o : 8'hxx;
    end

    int total = 0;
    int bad   = 0;
    bit last_wr = 1'b1;   // model of "port served last", resets to write

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_ram);
    endtask

    function automatic logic [31:0] ref_word(input logic [AW-1:0] a);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        return {ref_mem[b], ref_mem[b + 19'd1], ref_mem[b + 19'd2], ref_mem[b + 19'd3]};
    endfunction

    // Continuous protocol checks.
    logic [31:0] prev_q;
    logic        prev_ack;
    always @(negedge clk_ram) begin
        if (reset_n === 1'b1) begin
            check_eq("we_needs_oe", 64'(sram_we_n | sram_dq_oe), 64'd1);
            check_eq("vid_q_stable", 64'((vid_q !== prev_q) && (vid_ack === prev_ack)), 64'd0);
        end
        prev_q   = vid_q;
        prev_ack = vid_ack;
    end

    task automatic do_read(input logic [AW-1:0] a, input string tag);
        logic p;
        int   t;
        vid_addr = a;
        p = vid_ack;
        vid_req = ~vid_req;
        t = 0;
        do begin
            tick();
            t++;
        end while (vid_ack === p && t < 20);
        check_eq({tag, "_lat"}, 64'(t), 64'd5);
        check_eq({tag, "_data"}, 64'(vid_q), 64'(ref_word(a)));
        last_wr = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] va, wa;
        logic [7:0]    wd;
        logic          pv, pw;
        int            kind, rd_at, wr_at, n, nv, nw, last_t;
        bit            rd_done, wr_done, expect_v, served_v;

        reset_n = 1'b0;
        vid_req = 1'b0; wr_req = 1'b0;
        vid_addr = '0;  wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 'h1000; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i];
        end
        for (int i = 'h7F000; i < 'h80000; i++) begin
            mem[i] = 8'($urandom); ref_mem[i] = mem[i];
        end
        mem['h100] = 8'h11; mem['h101] = 8'h22; mem['h102] = 8'h33; mem['h103] = 8'h44;
        for (int i = 'h100; i < 'h104; i++) ref_mem[i] = mem[i];

        // Reset with both requests toggled.
        repeat (2) tick();
        vid_addr = 19'h00101; wr_addr = 19'h7FFFF; wr_data = 8'hA5;
        vid_req = 1'b1; wr_req = 1'b1;
        tick();
        check_eq("rst_addr", 64'(sram_addr), 64'd0);
        check_eq("rst_dq_o", 64'(sram_dq_o), 64'd0);
        check_eq("rst_oe", 64'(sram_dq_oe), 64'd0);
        check_eq("rst_we_n", 64'(sram_we_n), 64'd1);
        check_eq("rst_vid_q", 64'(vid_q), 64'd0);
        check_eq("rst_vid_ack", 64'(vid_ack), 64'd0);
        check_eq("rst_wr_ack", 64'(wr_ack), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;

        // Video served first: byte addresses 0x100..0x103 on successive cycles.
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("rd_addr", 64'(sram_addr), 64'('h100 + i));
            check_eq("rd_oe", 64'(sram_dq_oe), 64'd0);
            check_eq("rd_we_n", 64'(sram_we_n), 64'd1);
            check_eq("rd_ack_early", 64'(vid_ack), 64'd0);
            check_eq("rd_busy", 64'(busy), 64'd1);
        end
        tick();
        check_eq("rd_word", 64'(vid_q), 64'h11223344);
        check_eq("rd_ack", 64'(vid_ack), 64'd1);
        last_wr = 1'b0;

        // Pending write follows: strobe low exactly WRP cycles.
        for (int w = 0; w <= 5; w++) begin
            tick();
            check_eq("wr_we_n", 64'(sram_we_n), 64'((w >= 1 && w <= WRP) ? 0 : 1));
            check_eq("wr_oe", 64'(sram_dq_oe), 64'((w <= WRP + 1) ? 1 : 0));
            check_eq("wr_ack_t", 64'(wr_ack), 64'((w == WRP + 2) ? 1 : 0));
            check_eq("wr_addr_hold", 64'(sram_addr), 64'h7FFFF);
            check_eq("wr_dq_hold", 64'(sram_dq_o), 64'hA5);
        end
        check_eq("wr_mem", 64'(mem['h7FFFF]), 64'hA5);
        ref_mem['h7FFFF] = 8'hA5;
        last_wr = 1'b1;
        do_read(19'h7FFFD, "readback");

        // Randomized single and contending transactions.
        for (int r = 0; r < 40; r++) begin
            kind = $urandom_range(0, 2);
            va = AW'($urandom_range(0, 'h3FF));
            wa = AW'($urandom_range(0, 'h3FF));
            wd = 8'($urandom);
            check_eq("idle_before", 64'(busy), 64'd0);
            rd_at = 0; wr_at = 0;
            if (kind == 0) rd_at = 5;
            else if (kind == 1) wr_at = WRP + 3;
            else if (last_wr) begin rd_at = 5; wr_at = 5 + WRP + 3; end
            else begin wr_at = WRP + 3; rd_at = WRP + 3 + 5; end
            vid_addr = va; wr_addr = wa; wr_data = wd;
            pv = vid_ack; pw = wr_ack;
            if (rd_at != 0) vid_req = ~vid_req;
            if (wr_at != 0) wr_req = ~wr_req;
            rd_done = (rd_at == 0); wr_done = (wr_at == 0);
            for (int t = 1; t <= 20 && !(rd_done && wr_done); t++) begin
                tick();
                if (vid_ack !== pv) begin
                    pv = vid_ack; rd_done = 1'b1;
                    check_eq("rnd_rd_lat", 64'(t), 64'(rd_at));
                    check_eq("rnd_rd_data", 64'(vid_q), 64'(ref_word(va)));
                end
                if (wr_ack !== pw) begin
                    pw = wr_ack; wr_done = 1'b1;
                    check_eq("rnd_wr_lat", 64'(t), 64'(wr_at));
                    check_eq("rnd_wr_mem", 64'(mem[wa]), 64'(wd));
                    ref_mem[wa] = wd;
                end
            end
            if (!(rd_done && wr_done)) check_eq("rnd_timeout", 64'd0, 64'd1);
            if (kind == 0) last_wr = 1'b0;
            else if (kind == 1) last_wr = 1'b1;
        end

        // Contention: both re-toggled on every ack -> strict alternation.
        expect_v = last_wr;
        va = AW'($urandom_range(0, 'h3FF));
        wa = AW'($urandom_range(0, 'h3FF));
        wd = 8'($urandom);
        vid_addr = va; wr_addr = wa; wr_data = wd;
        pv = vid_ack; pw = wr_ack;
        vid_req = ~vid_req; wr_req = ~wr_req;
        n = 0; nv = 1; nw = 1;
        for (int t = 0; t < 200 && n < 8; t++) begin
            tick();
            if (vid_ack !== pv) begin
                pv = vid_ack; served_v = 1'b1; n++;
                check_eq("order", 64'(served_v), 64'(expect_v));
                check_eq("cont_rd_data", 64'(vid_q), 64'(ref_word(va)));
                expect_v = 1'b0; last_wr = 1'b0;
                if (nv < 4) begin
                    va = AW'($urandom_range(0, 'h3FF));
                    vid_addr = va; vid_req = ~vid_req; nv++;
                end
            end
            if (wr_ack !== pw) begin
                pw = wr_ack; served_v = 1'b0; n++;
                check_eq("order", 64'(served_v), 64'(expect_v));
                check_eq("cont_wr_mem", 64'(mem[wa]), 64'(wd));
                ref_mem[wa] = wd;
                expect_v = 1'b1; last_wr = 1'b1;
                if (nw < 4) begin
                    wa = AW'($urandom_range(0, 'h3FF));
                    wd = 8'($urandom);
                    wr_addr = wa; wr_data = wd; wr_req = ~wr_req; nw++;
                end
            end
        end
        if (n < 8) check_eq("cont_timeout", 64'd0, 64'd1);

        // Streaming reads: one word every 5 cycles.
        va = AW'($urandom_range(0, 'h3FF));
        vid_addr = va; pv = vid_ack; vid_req = ~vid_req;
        n = 0; last_t = 0;
        for (int t = 1; t <= 100 && n < 6; t++) begin
            tick();
            if (vid_ack !== pv) begin
                pv = vid_ack; n++;
                check_eq("stream_period", 64'(t - last_t), 64'd5);
                check_eq("stream_data", 64'(vid_q), 64'(ref_word(va)));
                last_t = t;
                if (n < 6) begin
                    va = AW'($urandom_range(0, 'h3FF));
                    vid_addr = va; vid_req = ~vid_req;
                end
            end
        end
        if (n < 6) check_eq("stream_timeout", 64'd0, 64'd1);
        last_wr = 1'b0;

        // Reset in the middle of the write strobe.
        wr_addr = 19'h7FF00; wr_data = 8'h5A; wr_req = ~wr_req;
        tick();
        tick();
        check_eq("mid_we_low", 64'(sram_we_n), 64'd0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_we_n", 64'(sram_we_n), 64'd1);
        check_eq("mid_rst_oe", 64'(sram_dq_oe), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_ack", 64'(wr_ack), 64'd0);
        vid_req = 1'b0; wr_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        last_wr = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_busy", 64'(busy), 64'd0);
        check_eq("post_rst_ack", 64'(wr_ack), 64'd0);
        check_eq("post_rst_we_n", 64'(sram_we_n), 64'd1);
        do_read(AW'($urandom_range(0, 'h3FF)), "post_rst_read");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
